// File: rtl/seq1011_frame_tx.sv
// seq1011_frame_tx: valid/ready payload word to serial frame (sync word, payload MSB-first, optional parity)
// Optional even-parity bit appended when SEQ_TX_PARITY_EN is defined.
module seq1011_frame_tx #(
    parameter logic [7:0] SYNC     = 8'b0000_1011,
    parameter int         SYNC_LEN = 4,
    parameter int         DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_seq,
    output logic              o_busy,
    output logic              o_last
);
    localparam int MAXL = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
`ifdef SEQ_TX_PARITY_EN
    localparam int FW = SYNC_LEN + DATA_W + 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR} state_t;
`else
    localparam int FW = SYNC_LEN + DATA_W;
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;
`endif
    localparam logic [CW-1:0] C_SYNC_END = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] C_DATA_END = CW'(DATA_W - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [FW-1:0] r_shift, w_shift_nxt;
    logic          r_last, w_last_nxt;
    logic          w_accept;
    logic [FW-1:0] w_frame;

    // The whole frame is latched at once and shifted out MSB-first; zeros shift in,
    // so o_seq is a plain flop that naturally reads 0 once the frame has drained.
`ifdef SEQ_TX_PARITY_EN
    assign w_frame = {SYNC[SYNC_LEN-1:0], i_data, ^i_data};
`else
    assign w_frame = {SYNC[SYNC_LEN-1:0], i_data};
`endif
    assign w_accept = i_valid & o_ready;
    assign o_seq    = r_shift[FW-1];
    assign o_last   = r_last;

    // State, bit counter, frame shifter and registered last-bit flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state: every phase transition is taken when the counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = C_SYNC_END;
                    w_shift_nxt = w_frame;
                end
            end
            ST_SYNC: begin
                w_shift_nxt = r_shift << 1;
                w_state_nxt = (r_cnt == '0) ? ST_DATA : ST_SYNC;
                w_cnt_nxt   = (r_cnt == '0) ? C_DATA_END : r_cnt - CW'(1);
            end
            ST_DATA: begin
                w_shift_nxt = r_shift << 1;
                w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
`ifdef SEQ_TX_PARITY_EN
                w_state_nxt = (r_cnt == '0) ? ST_PAR : ST_DATA;
`else
                w_state_nxt = (r_cnt == '0) ? ST_IDLE : ST_DATA;
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: begin
                w_shift_nxt = r_shift << 1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status outputs; last flag is computed one cycle ahead so it can be registered
    always_comb begin
        o_ready = (r_state == ST_IDLE) & ~rst;
        o_busy  = r_state != ST_IDLE;
`ifdef SEQ_TX_PARITY_EN
        w_last_nxt = w_state_nxt == ST_PAR;
`else
        w_last_nxt = (w_state_nxt == ST_DATA) && (w_cnt_nxt == '0);
`endif
    end
endmodule

// File: tb/tb_seq1011_frame_tx.sv
// tb_seq1011_frame_tx: directed checks of the 1011 frame transmitter
`timescale 1ns/1ps
module tb_seq1011_frame_tx;
    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       o_ready, o_seq, o_busy, o_last;
    int         n_cmp   = 0;
    int         n_err   = 0;

`ifdef SEQ_TX_PARITY_EN
    localparam int          FL     = 13;
    localparam logic [31:0] EXP_A5 = 32'b1011_1010_0101_0_0;
`else
    localparam int          FL     = 12;
    localparam logic [31:0] EXP_A5 = 32'b1011_1010_0101_0;
`endif

    seq1011_frame_tx dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_seq(o_seq),
        .o_busy(o_busy),
        .o_last(o_last)
    );

    always #5 clk = ~clk;

    // Expected frame bits, right-aligned, first bit in the most significant position
    function automatic logic [31:0] frame(input logic [7:0] d);
`ifdef SEQ_TX_PARITY_EN
        return {19'd0, 4'b1011, d, ^d};
`else
        return {20'd0, 4'b1011, d};
`endif
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    // Records len cycles of outputs, earliest cycle in the highest bit
    task automatic capture(input int len, output logic [31:0] s, output logic [31:0] l,
                           output logic [31:0] b, output logic [31:0] r);
        s = '0;
        l = '0;
        b = '0;
        r = '0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            s[len-1-k] = o_seq;
            l[len-1-k] = o_last;
            b[len-1-k] = o_busy;
            r[len-1-k] = o_ready;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({o_ready, o_seq, o_busy, o_last} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: ready/seq/busy/last=%b expected 0000", k, {o_ready, o_seq, o_busy, o_last});
            end
        end
        rst     = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({o_ready, o_seq, o_busy, o_last} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_release cyc%0d: ready/seq/busy/last=%b expected 1000", k, {o_ready, o_seq, o_busy, o_last});
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] s, l, b, r;
        send(8'hA5);
        capture(FL + 1, s, l, b, r);
        n_cmp++;
        if (s !== EXP_A5) begin
            n_err++;
            $display("FAIL single_seq: got %b expected %b", s, EXP_A5);
        end
        n_cmp++;
        if (l !== 32'b10) begin
            n_err++;
            $display("FAIL single_last: got %b expected %b", l, 32'b10);
        end
        n_cmp++;
        if (b !== (((32'd1 << FL) - 32'd1) << 1)) begin
            n_err++;
            $display("FAIL single_busy: got %b expected %b", b, ((32'd1 << FL) - 32'd1) << 1);
        end
        n_cmp++;
        if (r !== 32'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b expected %b", r, 32'b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s, l, b, r, es, eb;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'h00;
        @(posedge clk);
        #1 i_data = 8'hFF;
        capture(2 * FL + 1, s, l, b, r);
        i_valid = 1'b0;
        es = (frame(8'h00) << (FL + 1)) | frame(8'hFF);
        eb = (((32'd1 << FL) - 32'd1) << (FL + 1)) | ((32'd1 << FL) - 32'd1);
        n_cmp++;
        if (s !== es) begin
            n_err++;
            $display("FAIL b2b_seq: got %b expected %b", s, es);
        end
        n_cmp++;
        if (b !== eb) begin
            n_err++;
            $display("FAIL b2b_busy: got %b expected %b", b, eb);
        end
        n_cmp++;
        if (l !== ((32'd1 << (FL + 1)) | 32'd1)) begin
            n_err++;
            $display("FAIL b2b_last: got %b expected %b", l, (32'd1 << (FL + 1)) | 32'd1);
        end
        n_cmp++;
        if (r !== (32'd1 << FL)) begin
            n_err++;
            $display("FAIL b2b_ready: got %b expected %b", r, 32'd1 << FL);
        end
        capture(2, s, l, b, r);
        n_cmp++;
        if ({s[1:0], b[1:0], r[1:0]} !== 6'b00_00_11) begin
            n_err++;
            $display("FAIL b2b_tail: seq=%b busy=%b ready=%b expected 00/00/11", s[1:0], b[1:0], r[1:0]);
        end
    endtask

    task automatic test_input_stability();
        logic [31:0] s, l, b, r;
        send(8'h3C);
        fork
            capture(FL + 1, s, l, b, r);
            begin
                repeat (6) @(posedge clk);
                #1;
                i_data  = 8'hC3;
                i_valid = 1'b1;
            end
        join
        i_valid = 1'b0;
        n_cmp++;
        if (8'(s >> (FL - 11)) !== 8'h3C) begin
            n_err++;
            $display("FAIL stable_payload: got %b expected %b", 8'(s >> (FL - 11)), 8'h3C);
        end
        n_cmp++;
        if (s !== (frame(8'h3C) << 1)) begin
            n_err++;
            $display("FAIL stable_frame: got %b expected %b", s, frame(8'h3C) << 1);
        end
        capture(2, s, l, b, r);
        n_cmp++;
        if (b[1:0] !== 2'b00) begin
            n_err++;
            $display("FAIL stable_no_accept: busy=%b expected 00", b[1:0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] s, l, b, r;
        send(8'hF0);
        repeat (7) @(negedge clk);
        n_cmp++;
        if ({o_seq, o_busy} !== 2'b11) begin
            n_err++;
            $display("FAIL mid_bit6: seq/busy=%b expected 11", {o_seq, o_busy});
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_seq, o_busy, o_last, o_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_after_rst: seq/busy/last/ready=%b expected 0001", {o_seq, o_busy, o_last, o_ready});
        end
        capture(4, s, l, b, r);
        n_cmp++;
        if ({s[3:0], b[3:0], r[3:0]} !== 12'h00F) begin
            n_err++;
            $display("FAIL mid_no_resume: seq=%b busy=%b ready=%b expected 0000/0000/1111", s[3:0], b[3:0], r[3:0]);
        end
        send(8'h81);
        capture(FL + 1, s, l, b, r);
        n_cmp++;
        if (s !== (frame(8'h81) << 1)) begin
            n_err++;
            $display("FAIL mid_new_frame: got %b expected %b", s, frame(8'h81) << 1);
        end
        n_cmp++;
        if (l !== 32'b10) begin
            n_err++;
            $display("FAIL mid_new_last: got %b expected %b", l, 32'b10);
        end
    endtask

`ifdef SEQ_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] s, l, b, r;
        send(8'h07);
        capture(FL + 1, s, l, b, r);
        n_cmp++;
        if (s !== 32'b1011_0000_0111_1_0) begin
            n_err++;
            $display("FAIL par_07_seq: got %b expected %b", s, 32'b1011_0000_0111_1_0);
        end
        n_cmp++;
        if (l !== 32'b10) begin
            n_err++;
            $display("FAIL par_07_last: got %b expected %b", l, 32'b10);
        end
        send(8'hA5);
        capture(FL + 1, s, l, b, r);
        n_cmp++;
        if (s[1] !== 1'b0) begin
            n_err++;
            $display("FAIL par_a5_bit: got %b expected 0", s[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_input_stability();
        test_reset_mid_frame();
`ifdef SEQ_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq1011_frame_tx.md
# seq1011_frame_tx

Serial frame transmitter that produces the bit stream consumed by the team's 1011 sequence detectors. Each accepted payload word goes out on a single-bit line as a sync word (default 1011), then the payload MSB-first, then an optional parity bit. It sits between a parallel producer using a valid/ready handshake and the serial link, and is the source side of the detector test and link path.

## Interface
- `SYNC`, default 8'b0000_1011: sync pattern; the low `SYNC_LEN` bits are used, sent MSB-first.
- `SYNC_LEN`, default 4: number of sync bits, range 1..8.
- `DATA_W`, default 8: payload width, range 1..32.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `i_valid`  input  1: payload word offered.
- `i_data`  input  DATA_W: payload word.
- `o_ready`  output  1: block can accept a word this cycle.
- `o_seq`  output  1: serial output bit, registered.
- `o_busy`  output  1: a frame is in progress.
- `o_last`  output  1: high while the final bit of a frame is on `o_seq`.

## Operation
- FSM states: IDLE, SYNC, DATA, PAR. PAR exists only with the macro.
- IDLE:
  - `o_seq` is 0.
  - `o_ready = (state==IDLE) & ~rst`.
  - When `i_valid & o_ready` is sampled at an edge, latch `i_data` into the shift register, load the bit counter with `SYNC_LEN-1`, and go to SYNC.
- SYNC:
  - `o_seq = SYNC[cnt]`.
  - The counter decrements each cycle.
  - At `cnt==0`, go to DATA and load `cnt = DATA_W-1`.
- DATA:
  - `o_seq` = shift-register MSB; shift left one bit per cycle.
  - At `cnt==0`, go to PAR if the macro is defined, otherwise go to IDLE.
- PAR:
  - `o_seq` = parity bit computed at latch time.
  - Go to IDLE after one cycle.
- The counter is `$clog2(max(SYNC_LEN,DATA_W))` bits wide, minimum 1. The counter never wraps; every transition is taken at `cnt==0`.
- `i_data` and `i_valid` are ignored while `o_busy` is high. The latched copy is the only source for the frame.
- `o_busy` = state != IDLE.
- `o_last` is high on the final DATA bit, or on the PAR bit when the macro is defined.
- Frames are never truncated or merged. Frame length is `SYNC_LEN+DATA_W` bits, plus 1 with parity.
- Back-to-back traffic: the FSM always passes through IDLE for at least one cycle, so at least one `o_seq=0` gap bit separates frames. This bounds how much detector overlap the stream can trigger.
- Reset mid-frame:
  - The frame is discarded.
  - State goes to IDLE and the shift register clears.
  - `o_seq`, `o_busy` and `o_last` read 0 on the cycle after the reset edge.
  - No partial frame resumes.
- Reset values: `o_seq=0`, `o_busy=0`, `o_last=0`, and `o_ready=0` while `rst` is high.

## Timing
- Handshake accepted at edge N: first sync bit is on `o_seq` in the cycle after edge N. Latency is 1 cycle.
- Bit k of the frame (k from 0) is valid during cycle N+1+k.
- With defaults and no parity, `o_last` is high during cycle N+12. IDLE follows in cycle N+13, when `o_ready` is high again.
- Minimum frame period is `SYNC_LEN+DATA_W+1` cycles without parity, +1 with parity.
- `rst` is sampled only on the `clk` rising edge. There is no asynchronous path.

## Configuration
- Macro `SEQ_TX_PARITY_EN`.
- Defined:
  - PAR state is present.
  - One even-parity bit (XOR of all payload bits) is appended after the payload.
  - `o_last` moves to the parity bit.
- Undefined:
  - No PAR state and no parity logic.
  - The frame ends on the payload LSB.

## Test plan
- Reset: hold `rst=1` for 3 cycles with `i_valid=1`, `i_data=8'hFF` -> `o_ready=0` and `o_seq=0` throughout. After release, `o_ready=1`, and no frame has started before the first accepted handshake.
- Single frame, no macro: accept 8'hA5 at edge N -> `o_seq` reads 1,0,1,1,1,0,1,0,0,1,0,1 over cycles N+1..N+12. `o_last` is high only at N+12, `o_busy` is high N+1..N+12, and `o_ready` returns at N+13.
- Back-to-back: `i_valid` held high with 8'h00 then 8'hFF -> bit stream 1011_00000000, 0, 1011_11111111, with exactly one 0 gap bit between the frames.
- Input stability: change `i_data` from 8'h3C to 8'hC3 during the DATA state -> the transmitted payload remains 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert `rst` for one cycle on frame bit 6 -> `o_seq`, `o_busy` and `o_last` read 0 the next cycle. After release, a new 8'h81 frame transmits completely with correct bits.
- `SEQ_TX_PARITY_EN`: 8'h07 -> 13-bit frame ending with parity 1, and `o_last` on bit 12. 8'hA5 -> parity 0.
